// File: rtl/parity_serializer.sv
// parity_serializer: loads a WIDTH-bit word, shifts it out LSB first, then one odd/even parity bit.
// Optional PARITY_ERR_INJECT_EN adds err_inj, which inverts the parity bit of the loaded frame.
module parity_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             odd,
`ifdef PARITY_ERR_INJECT_EN
    input  logic             err_inj,
`endif
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof,
    output logic             par_flag
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             par, par_n, inj, accept;

`ifdef PARITY_ERR_INJECT_EN
    assign inj = err_inj;
`else
    assign inj = 1'b0;
`endif

    // ready is a registered output and is high exactly in IDLE and PARITY
    assign accept = load && ready;

    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        par_n   = par;
        if (accept) begin
            state_n = SHIFT;
            sreg_n  = din;
            cnt_n   = '0;
            par_n   = (^din) ^ odd ^ inj;
        end else if (state == SHIFT) begin
            state_n = (cnt == LAST) ? PARITY : SHIFT;
            cnt_n   = (cnt == LAST) ? cnt : cnt + 1'b1;
            sreg_n  = (cnt == LAST) ? sreg : sreg >> 1;
        end else begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            par        <= 1'b0;
            ready      <= 1'b1;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sof        <= 1'b0;
            par_flag   <= 1'b0;
        end else begin
            state      <= state_n;
            sreg       <= sreg_n;
            cnt        <= cnt_n;
            par        <= par_n;
            ready      <= state_n != SHIFT;
            sout       <= (state_n == SHIFT) ? sreg_n[0] : (state_n == PARITY) ? par_n : 1'b0;
            sout_valid <= state_n != IDLE;
            sof        <= accept;
            par_flag   <= state_n == PARITY;
        end
    end
endmodule

// File: tb/tb_parity_serializer.sv
// tb_parity_serializer: random and directed frames checked against a frame-level queue model.
module tb_parity_serializer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din = '0;
    logic       odd = 1'b0;
    logic       err_inj = 1'b0;
    logic       load = 1'b0;
    logic       ready, sout, sout_valid, sof, par_flag;

    int checks = 0;
    int failures = 0;
    logic [4:0]  exp_out = 5'b10000;
    logic [4:0]  q[$];
    logic [15:0] hist = '0;

    parity_serializer #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .odd(odd),
`ifdef PARITY_ERR_INJECT_EN
        .err_inj(err_inj),
`endif
        .load(load), .ready(ready), .sout(sout), .sout_valid(sout_valid),
        .sof(sof), .par_flag(par_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Frame as seen on {ready,sout,sout_valid,sof,par_flag}: four data cycles, then parity.
    task automatic cyc(input logic l, input logic [3:0] d, input logic o, input logic e);
        int ones;
        logic p;
        load = l; din = d; odd = o; err_inj = e;
        if (l && exp_out[4]) begin
            ones = $countones(d);
            p = o ? (ones % 2 == 0) : (ones % 2 == 1);
`ifdef PARITY_ERR_INJECT_EN
            p = p ^ e;
`endif
            for (int i = 0; i < 4; i++) q.push_back({1'b0, d[i], 1'b1, i == 0, 1'b0});
            q.push_back({1'b1, p, 1'b1, 1'b0, 1'b1});
        end
        exp_out = (q.size() != 0) ? q.pop_front() : 5'b10000;
        @(posedge clk);
        @(negedge clk);
        check("outputs", {11'd0, ready, sout, sout_valid, sof, par_flag}, {11'd0, exp_out});
        hist = {hist[14:0], sout};
    endtask

    task automatic async_reset();
        load = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_reset", {11'd0, ready, sout, sout_valid, sof, par_flag}, 16'b10000);
        q.delete();
        exp_out = 5'b10000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("reset", {11'd0, ready, sout, sout_valid, sof, par_flag}, 16'b10000);
        rst_n = 1'b1;
        cyc(1'b1, 4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'b0000, 1'b0, 1'b0);
        check("zero_odd", {11'd0, hist[4:0]}, 16'b00001);
        cyc(1'b1, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'b0000, 1'b0, 1'b0);
        check("zero_even", {11'd0, hist[5:1]}, 16'b00000);
        cyc(1'b1, 4'b1011, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'b0000, 1'b0, 1'b0);
        check("b1011_odd", {11'd0, hist[4:0]}, 16'b11010);
        cyc(1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b1011, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'b0000, 1'b0, 1'b0);
        check("b1011_even", {11'd0, hist[4:0]}, 16'b11011);
        cyc(1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b0001, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b1, 4'b0011, 1'b1, 1'b0);
        check("back_to_back", {6'd0, hist[9:0]}, 16'b1000011001);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b0001, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'b1111, 1'b0, 1'b0);
        check("ignored_load", {11'd0, hist[4:0]}, 16'b10000);
        cyc(1'b0, 4'b0000, 1'b0, 1'b0);
        cyc(1'b1, 4'b1011, 1'b1, 1'b0);
        cyc(1'b0, 4'b0000, 1'b0, 1'b0);
        async_reset();
        cyc(1'b1, 4'b0110, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'b0000, 1'b0, 1'b0);
`ifdef PARITY_ERR_INJECT_EN
        check("after_reset_inj", {11'd0, hist[4:0]}, 16'b01101);
`else
        check("after_reset", {11'd0, hist[4:0]}, 16'b01100);
`endif
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 9) < 6, 4'($urandom), 1'($urandom), 1'($urandom));
            if (i % 97 == 50) async_reset();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
